// File: rtl/miner_job_ctrl.sv
// Job/result sequencer for the SHA-256d nonce-search core (19-word job in, 10-word result out).
// Latency: core_en one cycle after job word 18; core stop one cycle after first found/done; frame the cycle after that.
// Backpressure: s_ready only in IDLE/LOAD; result words advance only on m_valid&m_ready, data held while stalled.
module miner_job_ctrl #(
    parameter int WORD_W = 32,
    parameter int H_W    = 256,
    parameter int M_W    = 96
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              core_en,
    output logic              core_reset,
    output logic [H_W-1:0]    core_prev_H,
    output logic [M_W-1:0]    core_M,
    output logic [H_W-1:0]    core_target,
    input  logic [WORD_W-1:0] core_nonce,
    input  logic [H_W-1:0]    core_hash,
    input  logic              core_found,
    input  logic              core_done,
    output logic              busy
);

    localparam int H_WORDS = H_W / WORD_W;
    localparam int M_WORDS = M_W / WORD_W;
    localparam logic [4:0] LD_M_FIRST = 5'(H_WORDS);
    localparam logic [4:0] LD_T_FIRST = 5'(H_WORDS + M_WORDS);
    localparam logic [4:0] LD_LAST    = 5'(2 * H_WORDS + M_WORDS - 1);
    localparam logic [3:0] TX_LAST    = 4'(H_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_STOP,
        S_TX
    } state_t;

    state_t state, state_nxt;

    logic [4:0]        ld_idx;
    logic [3:0]        tx_idx;
    logic              cap_found;
    logic              cap_done;
    logic [WORD_W-1:0] cap_nonce;
    logic [H_W-1:0]    cap_hash;
    logic              s_fire;
    logic              m_fire;

    assign s_ready    = (state == S_IDLE) || (state == S_LOAD);
    assign s_fire     = s_valid && s_ready;
    assign m_valid    = (state == S_TX);
    assign m_fire     = m_valid && m_ready;
    assign m_last     = m_valid && (tx_idx == TX_LAST);
    assign core_en    = (state == S_START);
    assign core_reset = reset || (state == S_STOP);
    assign busy       = !s_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: load, one-cycle start, wait for first result, one-cycle stop, drain frame
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (s_fire) state_nxt = S_LOAD;
            S_LOAD:  if (s_fire && ld_idx == LD_LAST) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (core_found || core_done) state_nxt = S_STOP;
            S_STOP:  state_nxt = S_TX;
            S_TX:    if (m_fire && tx_idx == TX_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Job shift-in, result capture and frame word index
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_idx      <= '0;
            tx_idx      <= '0;
            core_prev_H <= '0;
            core_M      <= '0;
            core_target <= '0;
            cap_found   <= 1'b0;
            cap_done    <= 1'b0;
            cap_nonce   <= '0;
            cap_hash    <= '0;
        end else begin
            // Words arrive MSB-first, so shifting left leaves word 0 in the top slot
            if (s_fire) begin
                if (ld_idx < LD_M_FIRST) begin
                    core_prev_H <= {core_prev_H[H_W-WORD_W-1:0], s_data};
                end else if (ld_idx < LD_T_FIRST) begin
                    core_M <= {core_M[M_W-WORD_W-1:0], s_data};
                end else begin
                    core_target <= {core_target[H_W-WORD_W-1:0], s_data};
                end
                ld_idx <= (ld_idx == LD_LAST) ? 5'd0 : ld_idx + 5'd1;
            end

            // Only WAIT captures, so the first event wins and STOP-cycle pulses are dropped
            if (state == S_WAIT) begin
                if (core_found) begin
                    cap_found <= 1'b1;
                    cap_done  <= 1'b0;
                    cap_nonce <= core_nonce;
                    cap_hash  <= core_hash;
                end else if (core_done) begin
                    cap_found <= 1'b0;
                    cap_done  <= 1'b1;
                    cap_nonce <= '0;
                    cap_hash  <= '0;
                end
            end

            if (m_fire) begin
                tx_idx <= (tx_idx == TX_LAST) ? 4'd0 : tx_idx + 4'd1;
            end
        end
    end

    // Frame word select: status, nonce, then hash most-significant word first
    always_comb begin
        m_data = '0;
        if (tx_idx == 4'd0) begin
            m_data = {{(WORD_W-2){1'b0}}, cap_found, cap_done};
        end else if (tx_idx == 4'd1) begin
            m_data = cap_nonce;
        end else begin
            for (int i = 0; i < H_WORDS; i++) begin
                if (tx_idx == 4'(i + 2)) m_data = cap_hash[H_W-1-WORD_W*i -: WORD_W];
            end
        end
    end

endmodule

// File: tb/tb_miner_job_ctrl.sv
// Bench for miner_job_ctrl: directed job/result sequences with random payloads,
// checked against a word-level model of the job layout and result frame.
module tb_miner_job_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic         core_en;
    logic         core_reset;
    logic [255:0] core_prev_H;
    logic [95:0]  core_M;
    logic [255:0] core_target;
    logic [31:0]  core_nonce;
    logic [255:0] core_hash;
    logic         core_found;
    logic         core_done;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]  job [19];
    logic [255:0] exp_h;
    logic [95:0]  exp_m;
    logic [255:0] exp_t;

    always #5 clk = ~clk;

    miner_job_ctrl dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .core_en(core_en), .core_reset(core_reset),
        .core_prev_H(core_prev_H), .core_M(core_M), .core_target(core_target),
        .core_nonce(core_nonce), .core_hash(core_hash),
        .core_found(core_found), .core_done(core_done), .busy(busy)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r = '0;
        for (int i = 0; i < 8; i++) r = (r << 32) | 256'($urandom);
        return r;
    endfunction

    // Called at #1 after a posedge with the DUT in IDLE; returns at #1 in the first WAIT cycle
    task automatic load_job(input bit seq, input bit noise);
        for (int i = 0; i < 19; i++) job[i] = seq ? 32'(i) : $urandom;
        exp_h = '0; exp_m = '0; exp_t = '0;
        for (int i = 0; i < 8; i++) exp_h = exp_h | (256'(job[i]) << (32 * (7 - i)));
        for (int i = 0; i < 3; i++) exp_m = exp_m | (96'(job[8 + i]) << (32 * (2 - i)));
        for (int i = 0; i < 8; i++) exp_t = exp_t | (256'(job[11 + i]) << (32 * (7 - i)));
        chk("s_ready_idle", s_ready, 1);
        chk("busy_idle", busy, 0);
        core_found = noise;
        core_done  = noise;
        core_nonce = $urandom;
        core_hash  = rand256();
        for (int i = 0; i < 19; i++) begin
            s_valid = 1'b1;
            s_data  = job[i];
            if (i == 18) chk("core_en_before_last", core_en, 0);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        core_found = 1'b0;
        core_done  = 1'b0;
        chk("core_en_start", core_en, 1);
        chk("s_ready_start", s_ready, 0);
        chk("busy_start", busy, 1);
        chk("core_prev_H", core_prev_H, exp_h);
        chk("core_M", 256'(core_M), 256'(exp_m));
        chk("core_target", core_target, exp_t);
        @(posedge clk); #1;
        chk("core_en_one_cycle", core_en, 0);
        chk("busy_wait", busy, 1);
    endtask

    // kind: 0 found, 1 done, 2 both. Ends in IDLE, or in reset aftermath when abort_at < 10.
    task automatic result_phase(input int kind, input int delay, input logic [31:0] nonce,
                                input logic [255:0] hash, input bit extra, input int hold_low,
                                input bit garbage, input int abort_at);
        logic [31:0]  fr [10];
        logic [255:0] eh;
        logic [31:0]  prev_dat;
        logic         prev_last;
        bit           prev_stall;
        bit           rdy;
        int           idx;
        int           cycles;
        eh    = (kind == 1) ? 256'd0 : hash;
        fr[0] = (kind == 1) ? 32'd1 : 32'd2;
        fr[1] = (kind == 1) ? 32'd0 : nonce;
        for (int i = 0; i < 8; i++) fr[2 + i] = 32'(eh >> (32 * (7 - i)));
        if (garbage) begin
            s_valid = 1'b1;
            s_data  = $urandom;
        end
        for (int d = 0; d < delay; d++) begin
            chk("no_result_yet", m_valid, 0);
            @(posedge clk); #1;
        end
        core_nonce = nonce;
        core_hash  = hash;
        core_found = (kind != 1);
        core_done  = (kind != 0);
        @(posedge clk); #1;
        core_found = 1'b0;
        core_done  = 1'b0;
        chk("core_reset_stop", core_reset, 1);
        chk("m_valid_stop", m_valid, 0);
        if (extra) begin
            core_found = 1'b1;
            core_nonce = ~nonce;
            core_hash  = ~hash;
        end
        @(posedge clk); #1;
        core_found = 1'b0;
        chk("core_reset_released", core_reset, 0);
        idx = 0; cycles = 0; prev_stall = 0; prev_dat = '0; prev_last = 1'b0;
        while (idx < 10 && idx != abort_at && cycles < 1000) begin
            if (prev_stall) begin
                chk("m_data_stable", m_data, prev_dat);
                chk("m_last_stable", m_last, prev_last);
            end
            rdy = (cycles < hold_low) ? 1'b0 : ($urandom_range(0, 3) != 0);
            m_ready = rdy;
            if (rdy) begin
                chk("m_valid_tx", m_valid, 1);
                chk($sformatf("frame_word%0d", idx), m_data, fr[idx]);
                chk($sformatf("m_last_word%0d", idx), m_last, (idx == 9));
                if (idx == 9) s_valid = 1'b0;
                idx++;
            end
            prev_stall = !rdy;
            prev_dat   = m_data;
            prev_last  = m_last;
            @(posedge clk); #1;
            cycles++;
        end
        m_ready = 1'b0;
        if (idx == abort_at) begin
            s_valid = 1'b0;
            reset = 1'b1;
            @(posedge clk); #1;
            chk("abort_m_valid", m_valid, 0);
            chk("abort_m_last", m_last, 0);
            chk("abort_core_reset", core_reset, 1);
            chk("abort_s_ready", s_ready, 1);
            reset = 1'b0;
            @(posedge clk); #1;
            chk("abort_prev_H_cleared", core_prev_H, 0);
            chk("abort_core_reset_off", core_reset, 0);
            return;
        end
        chk("frame_complete", idx, 10);
        chk("m_valid_after_frame", m_valid, 0);
        chk("s_ready_after_frame", s_ready, 1);
        chk("busy_after_frame", busy, 0);
        chk("job_unchanged_H", core_prev_H, exp_h);
        chk("job_unchanged_T", core_target, exp_t);
        @(posedge clk); #1;
        chk("single_frame", m_valid, 0);
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        core_nonce = '0; core_hash = '0; core_found = 1'b0; core_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_core_reset", core_reset, 1);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_core_en", core_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_prev_H", core_prev_H, 0);
        chk("rst_M", 256'(core_M), 0);
        chk("rst_target", core_target, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("core_reset_follows", core_reset, 0);

        // Sequential job, fixed found result
        load_job(1'b1, 1'b0);
        result_phase(0, 3, 32'h43F740C5, 256'hAB, 1'b0, 0, 1'b0, 10);
        // Exhaustion only
        load_job(1'b0, 1'b0);
        result_phase(1, 2, $urandom, rand256(), 1'b0, 0, 1'b0, 10);
        // found+done together, second found during STOP
        load_job(1'b0, 1'b0);
        result_phase(2, 0, $urandom, rand256(), 1'b1, 0, 1'b0, 10);
        // Receiver held off for 20 cycles, then random ready
        load_job(1'b0, 1'b0);
        result_phase(0, 1, $urandom, rand256(), 1'b0, 20, 1'b1, 10);

        // Reset after 7 job words, then a clean job with core noise during load
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        chk("partial_busy", busy, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("partial_rst_core_reset", core_reset, 1);
        chk("partial_rst_prev_H", core_prev_H, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        load_job(1'b0, 1'b1);
        result_phase(0, 2, $urandom, rand256(), 1'b0, 0, 1'b1, 10);

        // Randomized jobs
        for (int j = 0; j < 6; j++) begin
            load_job(1'b0, 1'(j % 2));
            result_phase($urandom_range(0, 2), $urandom_range(0, 6), $urandom, rand256(),
                         1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'($urandom_range(0, 1)), 10);
        end

        // Reset in the middle of a frame, then a fresh job
        load_job(1'b0, 1'b0);
        result_phase(0, 1, $urandom, rand256(), 1'b0, 0, 1'b0, 4);
        load_job(1'b0, 1'b0);
        result_phase(1, 1, $urandom, rand256(), 1'b0, 0, 1'b1, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
